// File: rtl/z80_pkg.sv
// Shared z80 definitions: arbiter FSM states and default timing constants.
package z80_pkg;

  localparam int unsigned MAX_HOLD_DEFAULT = 64;
  localparam int unsigned CPU_GAP_DEFAULT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE,
    ST_GAP
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin winner select: a lone request wins outright, a tie goes to rr.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] winner
);

  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = rr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Borrows the Z80 bus via BUSREQ_L/BUSACK_L and lends it to one of two requesters,
// bounding each grant to MAX_HOLD cycles and returning the bus to the CPU for CPU_GAP cycles.
module z80_bus_arbiter
  import z80_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
  parameter int unsigned CPU_GAP  = CPU_GAP_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_L,
  input  logic [1:0] req,
  input  logic       BUSACK_L,
  output logic       BUSREQ_L,
  output logic [1:0] gnt,
  output logic       preempt,
  output logic       busy
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] GAP_LAST  = 4'(CPU_GAP - 1);

  arb_state_e state, state_nxt;
  logic [1:0] gnt_nxt;
  logic [1:0] winner;
  logic       rr, rr_nxt;
  logic       preempt_nxt;
  logic [7:0] hold, hold_nxt;
  logic [3:0] gap, gap_nxt;
  logic       busreq_nxt;

  rr_pick2 u_pick (
    .req    (req),
    .rr     (rr),
    .winner (winner)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      rr       <= 1'b0;
      hold     <= '0;
      gap      <= '0;
      preempt  <= 1'b0;
      BUSREQ_L <= 1'b1;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr       <= rr_nxt;
      hold     <= hold_nxt;
      gap      <= gap_nxt;
      preempt  <= preempt_nxt;
      BUSREQ_L <= busreq_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    rr_nxt      = rr;
    hold_nxt    = hold;
    gap_nxt     = gap;
    preempt_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (req != '0) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (!BUSACK_L) begin
          if (req != '0) begin
            state_nxt = ST_GRANT;
            gnt_nxt   = winner;
            rr_nxt    = winner[0];
            hold_nxt  = '0;
          end else begin
            state_nxt = ST_RELEASE;
          end
        end
      end
      ST_GRANT: begin
        // Lost ack or dropped request beats expiry, so preempt only marks a forced withdrawal
        if (BUSACK_L || ((req & gnt) == '0)) begin
          state_nxt = ST_RELEASE;
          gnt_nxt   = '0;
        end else if (hold == HOLD_LAST) begin
          state_nxt   = ST_RELEASE;
          gnt_nxt     = '0;
          preempt_nxt = 1'b1;
        end else begin
          hold_nxt = hold + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (BUSACK_L) begin
          state_nxt = ST_GAP;
          gap_nxt   = '0;
        end
      end
      ST_GAP: begin
        if (gap == GAP_LAST) state_nxt = ST_IDLE;
        else                 gap_nxt   = gap + 4'd1;
      end
      default: begin
        state_nxt = ST_IDLE;
        gnt_nxt   = '0;
      end
    endcase

    busreq_nxt = !((state_nxt == ST_REQ) || (state_nxt == ST_GRANT));
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Bench for z80_bus_arbiter: one default-parameter instance and one with MAX_HOLD=8.
module tb_z80_bus_arbiter;
  import z80_pkg::*;

  logic       clk = 1'b0;
  logic       rst_L;
  logic [1:0] req;
  logic       ack_a, ack_b;
  logic       busreq_a, busreq_b;
  logic [1:0] gnt_a, gnt_b;
  logic       preempt_a, preempt_b;
  logic       busy_a, busy_b;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  z80_bus_arbiter u_a (
    .clk(clk), .rst_L(rst_L), .req(req), .BUSACK_L(ack_a),
    .BUSREQ_L(busreq_a), .gnt(gnt_a), .preempt(preempt_a), .busy(busy_a)
  );

  z80_bus_arbiter #(.MAX_HOLD(8), .CPU_GAP(4)) u_b (
    .clk(clk), .rst_L(rst_L), .req(req), .BUSACK_L(ack_b),
    .BUSREQ_L(busreq_b), .gnt(gnt_b), .preempt(preempt_b), .busy(busy_b)
  );

  task automatic do_reset();
    req   = 2'b00;
    ack_a = 1'b1;
    ack_b = 1'b1;
    rst_L = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst_L = 1'b0;
    #1;
    checks++; if (gnt_a !== 2'b00) begin failures++; $display("FAIL reset_gnt: got %b expected 00", gnt_a); end
    checks++; if (busreq_a !== 1'b1) begin failures++; $display("FAIL reset_busreq: got %b expected 1", busreq_a); end
    checks++; if (preempt_a !== 1'b0 || preempt_b !== 1'b0) begin failures++; $display("FAIL reset_preempt: got %b/%b expected 0/0", preempt_a, preempt_b); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b/%b expected 0/0", busy_a, busy_b); end
    checks++; if (u_a.rr !== 1'b0) begin failures++; $display("FAIL reset_rr: got %b expected 0", u_a.rr); end
    @(negedge clk);
    rst_L = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || busreq_a !== 1'b1) begin failures++; $display("FAIL idle_no_req: busy=%b busreq=%b expected 0/1", busy_a, busreq_a); end
  endtask

  task automatic test_single();
    logic [1:0] exp;
    int hold_cycles;
    int gap_cycles;
    bit busreq_low_in_gap;
    bit preempt_seen;
    do_reset();
    req = 2'b01;
    exp_q.push_back(2'b01);
    #1;
    checks++; if (busreq_a !== 1'b1) begin failures++; $display("FAIL single_busreq_early: got %b expected 1", busreq_a); end
    @(negedge clk);
    checks++; if (busreq_a !== 1'b0 || busy_a !== 1'b1 || gnt_a !== 2'b00) begin failures++; $display("FAIL single_req_state: busreq=%b busy=%b gnt=%b expected 0/1/00", busreq_a, busy_a, gnt_a); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (gnt_a !== 2'b00) begin failures++; $display("FAIL single_wait_ack: got %b expected 00", gnt_a); end
    end
    ack_a = 1'b0;
    @(negedge clk);
    exp = 2'bxx;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    checks++; if (gnt_a !== exp) begin failures++; $display("FAIL single_gnt: got %b expected %b", gnt_a, exp); end
    hold_cycles  = (gnt_a == 2'b01) ? 1 : 0;
    preempt_seen = 1'b0;
    repeat (9) begin
      @(negedge clk);
      if (gnt_a == 2'b01) hold_cycles++;
      if (preempt_a) preempt_seen = 1'b1;
    end
    checks++; if (hold_cycles != 10) begin failures++; $display("FAIL single_hold_len: got %0d expected 10", hold_cycles); end
    checks++; if (preempt_seen) begin failures++; $display("FAIL single_no_preempt: got 1 expected 0"); end
    req = 2'b00;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b00 || busreq_a !== 1'b1 || busy_a !== 1'b1 || preempt_a !== 1'b0) begin
      failures++; $display("FAIL single_release: gnt=%b busreq=%b busy=%b preempt=%b expected 00/1/1/0", gnt_a, busreq_a, busy_a, preempt_a);
    end
    ack_a = 1'b1;
    req   = 2'b01;
    gap_cycles = 0;
    busreq_low_in_gap = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy_a) break;
      gap_cycles++;
      if (!busreq_a) busreq_low_in_gap = 1'b1;
    end
    req = 2'b00;
    checks++; if (gap_cycles != 4) begin failures++; $display("FAIL single_gap_len: got %0d expected 4", gap_cycles); end
    checks++; if (busreq_low_in_gap) begin failures++; $display("FAIL single_gap_busreq: got 0 expected 1"); end
  endtask

  task automatic test_withdraw();
    bit gnt_seen;
    bit gap_seen;
    bit idle_reached;
    do_reset();
    req = 2'b10;
    gnt_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (gnt_a != 2'b00) gnt_seen = 1'b1;
    end
    req = 2'b00;
    repeat (3) begin
      @(negedge clk);
      if (gnt_a != 2'b00) gnt_seen = 1'b1;
    end
    ack_a = 1'b0;
    @(negedge clk);
    checks++; if (u_a.state !== ST_RELEASE || busreq_a !== 1'b1) begin failures++; $display("FAIL withdraw_release: state=%0d busreq=%b expected %0d/1", u_a.state, busreq_a, ST_RELEASE); end
    ack_a = 1'b1;
    gap_seen = 1'b0;
    idle_reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt_a != 2'b00) gnt_seen = 1'b1;
      if (u_a.state == ST_GAP) gap_seen = 1'b1;
      if (!busy_a) begin idle_reached = 1'b1; break; end
    end
    checks++; if (!idle_reached || !gap_seen) begin failures++; $display("FAIL withdraw_path: idle=%b gap=%b expected 1/1", idle_reached, gap_seen); end
    checks++; if (gnt_seen) begin failures++; $display("FAIL withdraw_no_gnt: got 1 expected 0"); end
  endtask

  task automatic test_ack_violation();
    logic [1:0] exp;
    bit idle_reached;
    do_reset();
    req = 2'b01;
    exp_q.push_back(2'b01);
    @(negedge clk);
    ack_a = 1'b0;
    @(negedge clk);
    exp = 2'bxx;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    checks++; if (gnt_a !== exp) begin failures++; $display("FAIL viol_gnt: got %b expected %b", gnt_a, exp); end
    @(negedge clk);
    ack_a = 1'b1;
    @(negedge clk);
    checks++; if (gnt_a !== 2'b00 || busreq_a !== 1'b1 || preempt_a !== 1'b0) begin failures++; $display("FAIL viol_drop: gnt=%b busreq=%b preempt=%b expected 00/1/0", gnt_a, busreq_a, preempt_a); end
    checks++; if (u_a.state !== ST_RELEASE) begin failures++; $display("FAIL viol_state: got %0d expected %0d", u_a.state, ST_RELEASE); end
    req = 2'b00;
    idle_reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy_a) begin idle_reached = 1'b1; break; end
    end
    checks++; if (!idle_reached) begin failures++; $display("FAIL viol_idle: got 0 expected 1"); end
  endtask

  task automatic test_reset_midgrant();
    logic [1:0] exp;
    do_reset();
    req = 2'b10;
    exp_q.push_back(2'b10);
    @(negedge clk);
    ack_a = 1'b0;
    @(negedge clk);
    exp = 2'bxx;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    checks++; if (gnt_a !== exp) begin failures++; $display("FAIL midrst_gnt: got %b expected %b", gnt_a, exp); end
    #2;
    rst_L = 1'b0;
    #1;
    checks++; if (gnt_a !== 2'b00 || busreq_a !== 1'b1) begin failures++; $display("FAIL midrst_async: gnt=%b busreq=%b expected 00/1", gnt_a, busreq_a); end
    checks++; if (u_a.rr !== 1'b0 || u_a.state !== ST_IDLE || busy_a !== 1'b0) begin failures++; $display("FAIL midrst_state: rr=%b state=%0d busy=%b expected 0/%0d/0", u_a.rr, u_a.state, busy_a, ST_IDLE); end
    req   = 2'b00;
    ack_a = 1'b1;
    @(negedge clk);
    rst_L = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    logic [1:0] prev;
    int grants_done;
    int run_len;
    int zero_run;
    int preempt_cnt;
    logic preempt_prev;
    do_reset();
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    req = 2'b11;
    prev = 2'b00;
    grants_done = 0;
    run_len = 0;
    zero_run = 0;
    preempt_cnt = 0;
    preempt_prev = 1'b0;
    for (int cyc = 0; cyc < 200 && grants_done < 4; cyc++) begin
      @(negedge clk);
      ack_b = busreq_b;
      if (preempt_b) begin
        preempt_cnt++;
        checks++; if (preempt_prev) begin failures++; $display("FAIL cont_preempt_width: got 2+ cycles expected 1"); end
      end
      preempt_prev = preempt_b;
      if (gnt_b != 2'b00) begin
        if (prev == 2'b00) begin
          exp = 2'bxx;
          if (exp_q.size() != 0) exp = exp_q.pop_front();
          checks++; if (gnt_b !== exp) begin failures++; $display("FAIL cont_winner: got %b expected %b", gnt_b, exp); end
          if (grants_done > 0) begin
            checks++; if (zero_run != 7) begin failures++; $display("FAIL cont_gap: got %0d idle cycles expected 7", zero_run); end
          end
          run_len = 1;
        end else begin
          run_len++;
        end
      end else begin
        if (prev != 2'b00) begin
          checks++; if (run_len != 8) begin failures++; $display("FAIL cont_len: got %0d expected 8", run_len); end
          grants_done++;
          zero_run = 1;
        end else begin
          zero_run++;
        end
      end
      prev = gnt_b;
    end
    checks++; if (grants_done != 4) begin failures++; $display("FAIL cont_timeout: got %0d grants expected 4", grants_done); end
    checks++; if (preempt_cnt != 4) begin failures++; $display("FAIL cont_preempt_cnt: got %0d expected 4", preempt_cnt); end
    req = 2'b00;
    ack_b = 1'b1;
  endtask

  initial begin
    rst_L = 1'b0;
    req   = 2'b00;
    ack_a = 1'b1;
    ack_b = 1'b1;
    test_reset();
    test_single();
    test_withdraw();
    test_ack_violation();
    test_reset_midgrant();
    test_contention();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
